dcache_resp: RTL
================

DCACHE_RESP -- requirements
Module: dcache_resp

Interface
REQ-001 Parameter: DEPTH_WORDS, 1024, number of 32-bit words in data RAM (power of two).
REQ-002 Parameter: SB_DEPTH, 2, store-buffer entries (power of two, >=2).
REQ-003 Reset rst_n, asynchronous, active-low; clock clk.
REQ-004 clk  input  1  clock.
REQ-005 rst_n  input  1  async active-low reset.
REQ-006 Mem_DcacheEN  input  1  access request this cycle.
REQ-007 Mem_DcacheRd  input  1  1=load, 0=store.
REQ-008 Mem_DcacheWidth  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-009 Mem_DcacheAddr  input  32  byte address.
REQ-010 Mem_DcacheSign  input  1  sign-extend load result.
REQ-011 EXMem_Rs2Data  input  32  store data, right-aligned.
REQ-012 Dcache_DataRd  output  32  load result, same cycle.
REQ-013 Dcache_Stall  output  1  load not serviced this cycle; requester holds inputs.
REQ-014 Dcache_SbEmpty  output  1  store buffer empty.
REQ-015 Dcache_Misalign  output  1  misaligned access flag.

Function
REQ-016 Word index = Addr[log2(DEPTH_WORDS)+1:2]; upper bits ignored (wrap modulo DEPTH_WORDS).
REQ-017 Store (EN=1, Rd=0, not misaligned, width!=11) pushes {word index, 4-bit byte mask, lane-shifted data} into the store-buffer FIFO tail in the same cycle.
REQ-018 Byte mask: byte -> 1<<Addr[1:0]; half -> 0011<<Addr[1]*2; word -> 1111; data shifted into matching lanes.
REQ-019 Drain: in any cycle with no serviced load and FIFO non-empty, head entry is written to RAM (masked bytes only) at posedge and popped.
REQ-020 Store into a full FIFO: drain and push occur in the same cycle; count stays SB_DEPTH; stores never stall.
REQ-021 Load serviced when no valid FIFO entry matches its word index: Dcache_DataRd = combinational RAM read, lane-selected by Addr[1:0] (byte) or Addr[1] (half).
REQ-022 Load result: byte/half sign-extended when Sign=1, else zero-extended; word ignores Sign.
REQ-023 Load hazard: any valid FIFO entry with equal word index -> Dcache_Stall=1, Dcache_DataRd=0, drain continues; load serviced in first cycle with no match.
REQ-024 Dcache_Stall=0 whenever EN=0 or Rd=0.
REQ-025 Dcache_DataRd=0 when EN=0, on store cycles, on width 11, and on stalled or misaligned loads.
REQ-026 Width 11: no RAM or FIFO effect, no stall, no misalign flag.
REQ-027 FIFO pointers wrap modulo SB_DEPTH; count range 0..SB_DEPTH; Dcache_SbEmpty = (count==0), registered-state derived.
REQ-028 RAM holds no reset; writes occur only through drain.

Reset
REQ-029 rst_n low: FIFO pointers and count to 0, all entry valid bits cleared, Dcache_SbEmpty=1, Dcache_Stall=0, Dcache_Misalign=0, Dcache_DataRd=0.
REQ-030 Reset mid-operation discards all buffered stores; RAM keeps drained data only.

Configuration
REQ-031 Macro DCACHE_MISALIGN_CHK_EN defined: half with Addr[0]=1 or word with Addr[1:0]!=0 sets Dcache_Misalign=1 combinationally; store not pushed; load returns 0, no stall.
REQ-032 Macro undefined: Dcache_Misalign tied 0; misaligned half clears Addr[0], misaligned word clears Addr[1:0], access proceeds normally.

Verification
REQ-033 Reset, SW 0x12345678 @0x100, idle 1 cycle, LW @0x100 -> 0x12345678, Stall=0, SbEmpty=1.
REQ-034 Word 0x100 = 0x80FF7F01: LB @0x102 Sign=1 -> 0xFFFFFFFF; LBU @0x103 -> 0x00000080; LH @0x102 Sign=1 -> 0xFFFF80FF.
REQ-035 SB 0xAA @0x201 then LW @0x200 next cycle -> Stall=1 one cycle, then data bits[15:8]=0xAA, Stall=0.
REQ-036 SW @0x0, 0x4, 0x8 back-to-back -> no stall, count never exceeds 2, after 2 idle cycles SbEmpty=1, all three words readable.
REQ-037 With DCACHE_MISALIGN_CHK_EN: SW @0x102 -> Misalign=1, word 0x100 unchanged, SbEmpty=1; without macro: same stores to 0x100.
REQ-038 Push two stores, assert rst_n low mid-drain -> SbEmpty=1 immediately, undrained store absent from RAM.

Source files
------------

// File: rtl/dcache_resp_if.sv
// rtl/dcache_resp_if.sv - memory-stage request / load-response bundle for dcache_resp
interface dcache_resp_if;
    logic        Mem_DcacheEN;
    logic        Mem_DcacheRd;
    logic [1:0]  Mem_DcacheWidth;
    logic [31:0] Mem_DcacheAddr;
    logic        Mem_DcacheSign;
    logic [31:0] EXMem_Rs2Data;
    logic [31:0] Dcache_DataRd;
    logic        Dcache_Stall;
    logic        Dcache_SbEmpty;
    logic        Dcache_Misalign;

    modport master (
        output Mem_DcacheEN, Mem_DcacheRd, Mem_DcacheWidth, Mem_DcacheAddr,
               Mem_DcacheSign, EXMem_Rs2Data,
        input  Dcache_DataRd, Dcache_Stall, Dcache_SbEmpty, Dcache_Misalign
    );

    modport slave (
        input  Mem_DcacheEN, Mem_DcacheRd, Mem_DcacheWidth, Mem_DcacheAddr,
               Mem_DcacheSign, EXMem_Rs2Data,
        output Dcache_DataRd, Dcache_Stall, Dcache_SbEmpty, Dcache_Misalign
    );
endinterface

// File: rtl/dcache_resp.sv
// rtl/dcache_resp.sv - data RAM with store buffer and same-cycle loads
// Optional DCACHE_MISALIGN_CHK_EN: flag misaligned half/word accesses instead of force-aligning them.
module dcache_resp #(
    parameter int DEPTH_WORDS = 1024,
    parameter int SB_DEPTH    = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    dcache_resp_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = $clog2(SB_DEPTH + 1);

    logic [31:0] mem [DEPTH_WORDS];

    logic [SB_DEPTH-1:0] sb_vld_q, sb_vld_d;
    logic [IDX_W-1:0]    sb_idx_q  [SB_DEPTH];
    logic [IDX_W-1:0]    sb_idx_d  [SB_DEPTH];
    logic [3:0]          sb_mask_q [SB_DEPTH];
    logic [3:0]          sb_mask_d [SB_DEPTH];
    logic [31:0]         sb_data_q [SB_DEPTH];
    logic [31:0]         sb_data_d [SB_DEPTH];
    logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [1:0]       width;
    logic [31:0]      eff_addr;
    logic             misalign;
    logic             acc_ok, is_load, is_store, hazard, serviced, drain;
    logic [IDX_W-1:0] word_idx;
    logic [3:0]       st_mask;
    logic [31:0]      st_data, rd_word, ld_shift, ld_val;
    logic             unused_addr_hi;

    assign width = bus.Mem_DcacheWidth;

    always_comb begin
        eff_addr = bus.Mem_DcacheAddr;
        misalign = 1'b0;
`ifdef DCACHE_MISALIGN_CHK_EN
        misalign = (width == 2'b01 && bus.Mem_DcacheAddr[0]) ||
                   (width == 2'b10 && bus.Mem_DcacheAddr[1:0] != 2'b00);
`else
        // Without checking, a misaligned access is silently snapped down to its natural boundary.
        if (width == 2'b01)
            eff_addr[0] = 1'b0;
        else if (width == 2'b10)
            eff_addr[1:0] = 2'b00;
`endif
    end

    assign unused_addr_hi = ^eff_addr[31:IDX_W+2];
    assign word_idx = eff_addr[IDX_W+1:2];
    assign acc_ok   = bus.Mem_DcacheEN && width != 2'b11 && !misalign;
    assign is_load  = acc_ok && bus.Mem_DcacheRd;
    assign is_store = acc_ok && !bus.Mem_DcacheRd;

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++)
            if (sb_vld_q[i] && sb_idx_q[i] == word_idx)
                hazard = 1'b1;
    end

    assign serviced = is_load && !hazard;
    // The RAM port is free whenever no load is being returned, so the head drains then.
    assign drain    = !serviced && cnt_q != '0;

    always_comb begin
        case (width)
            2'b00:   st_mask = 4'b0001 << eff_addr[1:0];
            2'b01:   st_mask = eff_addr[1] ? 4'b1100 : 4'b0011;
            default: st_mask = 4'b1111;
        endcase
        st_data = bus.EXMem_Rs2Data << {eff_addr[1:0], 3'b000};
    end

    assign rd_word  = mem[word_idx];
    assign ld_shift = rd_word >> {eff_addr[1:0], 3'b000};

    always_comb begin
        case (width)
            2'b00:   ld_val = {{24{bus.Mem_DcacheSign & ld_shift[7]}}, ld_shift[7:0]};
            2'b01:   ld_val = {{16{bus.Mem_DcacheSign & ld_shift[15]}}, ld_shift[15:0]};
            default: ld_val = rd_word;
        endcase
    end

    always_comb begin
        sb_vld_d  = sb_vld_q;
        sb_idx_d  = sb_idx_q;
        sb_mask_d = sb_mask_q;
        sb_data_d = sb_data_q;
        head_d    = head_q;
        tail_d    = tail_q;
        if (drain) begin
            sb_vld_d[head_q] = 1'b0;
            head_d           = head_q + 1'b1;
        end
        // Push after pop: when full, head == tail and the new entry reuses the drained slot.
        if (is_store) begin
            sb_vld_d[tail_q]  = 1'b1;
            sb_idx_d[tail_q]  = word_idx;
            sb_mask_d[tail_q] = st_mask;
            sb_data_d[tail_q] = st_data;
            tail_d            = tail_q + 1'b1;
        end
        cnt_d = cnt_q + CNT_W'(is_store) - CNT_W'(drain);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_vld_q <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            cnt_q    <= '0;
        end else begin
            sb_vld_q <= sb_vld_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        sb_idx_q  <= sb_idx_d;
        sb_mask_q <= sb_mask_d;
        sb_data_q <= sb_data_d;
    end

    always_ff @(posedge clk) begin
        if (drain) begin
            for (int b = 0; b < 4; b++)
                if (sb_mask_q[head_q][b])
                    mem[sb_idx_q[head_q]][8*b +: 8] <= sb_data_q[head_q][8*b +: 8];
        end
    end

    assign bus.Dcache_DataRd   = (rst_n && serviced) ? ld_val : 32'h0;
    assign bus.Dcache_Stall    = rst_n && is_load && hazard;
    assign bus.Dcache_SbEmpty  = cnt_q == '0;
    assign bus.Dcache_Misalign = rst_n && bus.Mem_DcacheEN && misalign;
endmodule
